// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Instruction-memory and IF/ID handshake bundle for fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, out_valid, out_pc, out_pc4, out_instr,
        input  mem_ack, mem_rdata, out_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_pc, out_pc4, out_instr,
        output mem_ack, mem_rdata, out_ready, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction prefetch queue, one outstanding request, flushable.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
    localparam logic [31:0]        c_align = ~32'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_req_addr;
    logic [31:0]        w_issue_addr;
    logic [31:0]        r_pc_mem    [DEPTH];
    logic [31:0]        r_instr_mem [DEPTH];
    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic               w_room;

    assign w_valid = (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Space is reserved at issue: the count used already includes this
    // cycle's push and pop, so an acked word always has a free slot.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_pop        = w_valid & bus.out_ready & ~bus.redirect;
        w_push       = (r_state == WAIT) & bus.mem_ack & ~bus.redirect;
        w_count_next = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        w_room       = (w_count_next < c_full);
        w_issue_addr = w_push ? (r_fetch_pc + 32'd4) : r_fetch_pc;
        case (r_state)
            IDLE: begin
                if (!bus.redirect && w_room) begin
                    w_issue      = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    w_state_next = bus.mem_ack ? IDLE : DISCARD;
                end else if (bus.mem_ack) begin
                    w_issue      = w_room;
                    w_state_next = w_room ? WAIT : IDLE;
                end
            end
            DISCARD: begin
                if (bus.mem_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= RESET_PC & c_align;
            r_req_addr <= RESET_PC & c_align;
        end else begin
            if (bus.redirect) begin
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_fetch_pc <= bus.redirect_pc & c_align;
            end else begin
                r_count <= w_count_next;
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            if (w_issue) begin
                r_req_addr <= w_issue_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req   = (r_state != IDLE);
    assign bus.mem_addr  = r_req_addr;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_valid ? r_pc_mem[r_rd_ptr] : '0;
    assign bus.out_pc4   = w_valid ? (r_pc_mem[r_rd_ptr] + 32'd4) : '0;
    assign bus.out_instr = w_valid ? r_instr_mem[r_rd_ptr] : '0;
endmodule
`default_nettype wire
